demux_1byn_reg: RTL and testbench
=================================

DEMUX_1BYN_REG -- requirements
Module: demux_1byn_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel.
REQ-002 SHALL have parameter N, default 4, output channel count (legal range 2..16).
REQ-003 SHALL have parameter SELW, default 2, select width; the instantiator sets SELW >= ceil(log2(N)).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port d  input  WIDTH  input data word.
REQ-007 SHALL have port sel  input  SELW  destination channel index.
REQ-008 SHALL have port bcast  input  1  broadcast request; when 1, the word goes to all channels and sel is ignored.
REQ-009 SHALL have port in_valid  input  1  producer offers d/sel/bcast.
REQ-010 SHALL have port in_ready  output  1  block accepts the offer this cycle.
REQ-011 SHALL have port y  output  N*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port y_valid  output  N  per-channel data-valid.
REQ-013 SHALL have port y_ready  input  N  per-channel consumer ready.
REQ-014 SHALL have port err  output  1  one-cycle pulse on a dropped out-of-range transfer.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of dropped transfers.

Function
REQ-016 SHALL hold one registered entry per channel: data register y[k] plus flag y_valid[k].
REQ-017 SHALL treat channel k as free when y_valid[k]==0 or y_ready[k]==1 (pass-through on the same edge).
REQ-018 SHALL drive in_ready combinationally: bcast=1 -> all N channels free; bcast=0 with sel<N -> channel sel free; bcast=0 with sel>=N -> 1.
REQ-019 SHALL accept a transfer on a rising clk edge where in_valid && in_ready.
REQ-020 SHALL, on an accepted unicast with sel<N, load y[sel]<=d and set y_valid[sel]<=1 on that edge (latency 1 cycle).
REQ-021 SHALL, on an accepted broadcast, load d into every y[k] and set every y_valid[k]<=1 on that edge.
REQ-022 SHALL, on an accepted unicast with sel>=N, leave all channels unchanged, pulse err=1 for the following cycle only, and increment drop_cnt.
REQ-023 SHALL saturate drop_cnt at 255; further drops still pulse err.
REQ-024 SHALL clear y_valid[k] on an edge where y_valid[k]&&y_ready[k] and channel k is not loaded on that edge.
REQ-025 SHALL give a load priority over a same-edge consume: y_valid[k] stays 1 and y[k] takes the new word.
REQ-026 SHALL hold y[k] unchanged while y_valid[k]==1 and y_ready[k]==0 (no overwrite; in_ready low for that target).
REQ-027 SHALL leave y[k] unchanged after consume; only y_valid[k] drops.
REQ-028 SHALL let channels drain independently; a stalled channel never blocks unicast transfers to other channels.
REQ-029 SHALL ignore sel, d and bcast when in_valid==0; no state changes.

Reset
REQ-030 SHALL, while rst==1 and independent of clk, force y=0, y_valid=0, err=0, drop_cnt=0.
REQ-031 SHALL drive in_ready as defined in REQ-018 during reset; any transfer offered during reset is not accepted.
REQ-032 SHALL discard all held entries on reset asserted mid-operation; the first transfer after deassertion is accepted on the first rising edge with rst==0.

Verification
REQ-033 SHALL pass this case (N=4, WIDTH=8): unicast sel=2, d=8'hA5, y_ready=4'b0000 -> next cycle y_valid=4'b0100, y[23:16]=8'hA5; a second offer to sel=2 sees in_ready=0.
REQ-034 SHALL pass this case: with channel 2 full and stalled, offer sel=1, d=8'h3C -> accepted, y_valid=4'b0110; channel 2 still holds 8'hA5.
REQ-035 SHALL pass this case: y_valid[0]=1, y_ready[0]=1, new unicast sel=0, d=8'h77 on the same edge -> y_valid[0] stays 1, y[7:0]=8'h77.
REQ-036 SHALL pass this case: bcast=1, d=8'h5A with one channel stalled -> in_ready=0; after that channel drains, the transfer is accepted and all four y[k]=8'h5A with y_valid=4'b1111.
REQ-037 SHALL pass this case (N=3, SELW=2): sel=3, d=8'hFF -> y_valid unchanged, err=1 for one cycle, drop_cnt=1; after 300 such drops drop_cnt=255.
REQ-038 SHALL pass this case: assert rst asynchronously between edges while y_valid=4'b1011 -> y_valid=0, y=0 and drop_cnt=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/demux_1byn_reg.sv
// 1-to-N registered demultiplexer: one holding register per output channel, unicast or
// broadcast loads, per-channel independent drain, and counting of out-of-range drops.
module demux_1byn_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   d,
    input  logic [SELW-1:0]    sel,
    input  logic               bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] y,
    output logic [N-1:0]       y_valid,
    input  logic [N-1:0]       y_ready,
    output logic               err,
    output logic [7:0]         drop_cnt
);

    logic         in_range_p0;
    logic         accept_p0;
    logic         drop_p0;
    logic [N-1:0] free_p0;
    logic [N-1:0] tgt_p0;
    logic [N-1:0] load_p0;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // stage 0: decode the offer against per-channel occupancy
    always_comb begin
        tgt_p0      = '0;
        in_range_p0 = (int'(sel) < N);
        free_p0     = ~y_valid | y_ready;
        for (int k = 0; k < N; k++) begin
            tgt_p0[k] = bcast || (in_range_p0 && (int'(sel) == k));
        end
    end

    // an out-of-range unicast targets no channel, so it is always ready and gets dropped
    assign in_ready  = ~|(tgt_p0 & ~free_p0);
    assign accept_p0 = in_valid && in_ready;
    assign load_p0   = accept_p0 ? tgt_p0 : '0;
    assign drop_p0   = accept_p0 && !bcast && !in_range_p0;

    // stage 1: channel registers, error pulse and drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y        <= '0;
            y_valid  <= '0;
            err      <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load_p0[k]) begin
                    y[k*WIDTH +: WIDTH] <= d;
                    y_valid[k]          <= 1'b1;
                end else if (y_ready[k]) begin
                    y_valid[k]          <= 1'b0;
                end
            end
            err <= drop_p0;
            if (drop_p0) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_demux_1byn_reg.sv
// Bench for demux_1byn_reg: directed scenarios plus random traffic, scored against
// per-channel queues of pending words and a simple drop-count model.
module tb_demux_1byn_reg;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   d;
    logic [SELW-1:0]    sel;
    logic               bcast;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] y;
    logic [N-1:0]       y_valid;
    logic [N-1:0]       y_ready;
    logic               err;
    logic [7:0]         drop_cnt;

    always #5 clk = ~clk;

    demux_1byn_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .d(d), .sel(sel), .bcast(bcast), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .err(err), .drop_cnt(drop_cnt)
    );

    // reference model: words waiting in each channel, last word written per channel
    logic [WIDTH-1:0] exp_q [N][$];
    logic [WIDTH-1:0] last_w [N];
    int               drops;
    bit               exp_err;
    int               passed;
    int               total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [N*WIDTH-1:0] model_y();
        logic [N*WIDTH-1:0] v;
        for (int k = 0; k < N; k++) v[k*WIDTH +: WIDTH] = last_w[k];
        return v;
    endfunction

    function automatic logic [N-1:0] model_valid();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = (exp_q[k].size() != 0);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            last_w[k] = '0;
        end
        drops   = 0;
        exp_err = 1'b0;
    endtask

    // predict in_ready from the current inputs and issue the expected result of the offer
    task automatic evaluate();
        logic [N-1:0] free;
        bit           in_range;
        bit           exp_rdy;
        for (int k = 0; k < N; k++) free[k] = (exp_q[k].size() == 0) || y_ready[k];
        in_range = (int'(sel) < N);
        exp_rdy  = 1'b1;
        if (bcast) exp_rdy = &free;
        else if (in_range) begin
            for (int k = 0; k < N; k++) if (k == int'(sel)) exp_rdy = free[k];
        end
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        exp_err = 1'b0;
        if (in_valid && exp_rdy) begin
            if (bcast) begin
                for (int k = 0; k < N; k++) begin
                    exp_q[k].push_back(d);
                    last_w[k] = d;
                end
            end else if (in_range) begin
                for (int k = 0; k < N; k++) begin
                    if (k == int'(sel)) begin
                        exp_q[k].push_back(d);
                        last_w[k] = d;
                    end
                end
            end else begin
                drops++;
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic step(input bit iv, input logic [SELW-1:0] s, input bit bc,
                        input logic [WIDTH-1:0] dd, input logic [N-1:0] yr);
        @(posedge clk);
        #1;
        check("y_valid", 64'(y_valid), 64'(model_valid()));
        check("y_data", 64'(y), 64'(model_y()));
        check("err", 64'(err), 64'(exp_err));
        check("drop_cnt", 64'(drop_cnt), 64'((drops > 255) ? 255 : drops));
        in_valid = iv;
        sel      = s;
        bcast    = bc;
        d        = dd;
        y_ready  = yr;
        #2;
        evaluate();
    endtask

    task automatic idle(input logic [N-1:0] yr);
        step(1'b0, 3'd0, 1'b0, 8'h00, yr);
    endtask

    // monitor: a word is taken by the consumer on each edge where valid and ready are both high
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (y_valid[k] && y_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        total++;
                        $display("FAIL consume_ch%0d actual=%0h required=no_pending_word",
                                 k, y[k*WIDTH +: WIDTH]);
                    end else begin
                        logic [WIDTH-1:0] w;
                        w = exp_q[k].pop_front();
                        check($sformatf("consume_ch%0d", k), 64'(y[k*WIDTH +: WIDTH]), 64'(w));
                    end
                end
            end
        end
    end

    initial begin
        passed   = 0;
        total    = 0;
        model_clear();
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = '0;
        bcast    = 1'b0;
        d        = '0;
        y_ready  = '0;
        #2;
        check("reset_y_valid", 64'(y_valid), 64'(0));
        check("reset_y", 64'(y), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_drop_cnt", 64'(drop_cnt), 64'(0));
        @(posedge clk);
        #3 rst = 1'b0;

        // unicast to a stalled channel, then a second offer to it
        step(1'b1, 3'd2, 1'b0, 8'hA5, 4'b0000);
        step(1'b1, 3'd2, 1'b0, 8'h11, 4'b0000);
        check("c033_valid", 64'(y_valid), 64'(4'b0100));
        check("c033_data", 64'(y[23:16]), 64'(8'hA5));
        check("c033_second_ready", 64'(in_ready), 64'(0));

        // another channel still accepts while channel 2 is stalled
        step(1'b1, 3'd1, 1'b0, 8'h3C, 4'b0000);
        idle(4'b0000);
        check("c034_valid", 64'(y_valid), 64'(4'b0110));
        check("c034_ch2_held", 64'(y[23:16]), 64'(8'hA5));
        check("c034_ch1_data", 64'(y[15:8]), 64'(8'h3C));

        // load wins over a same-edge consume
        step(1'b1, 3'd0, 1'b0, 8'h11, 4'b0000);
        step(1'b1, 3'd0, 1'b0, 8'h77, 4'b0001);
        idle(4'b0000);
        check("c035_valid0", 64'(y_valid[0]), 64'(1));
        check("c035_data0", 64'(y[7:0]), 64'(8'h77));

        // broadcast waits for the stalled channel to drain
        step(1'b1, 3'd0, 1'b1, 8'h5A, 4'b1011);
        check("c036_blocked", 64'(in_ready), 64'(0));
        step(1'b1, 3'd0, 1'b1, 8'h5A, 4'b0100);
        check("c036_accepted", 64'(in_ready), 64'(1));
        idle(4'b0000);
        check("c036_valid", 64'(y_valid), 64'(4'b1111));
        check("c036_data", 64'(y), 64'({4{8'h5A}}));
        idle(4'b1111);

        // out-of-range drop leaves channels alone and pulses err once
        step(1'b1, 3'd1, 1'b0, 8'h42, 4'b0000);
        step(1'b1, 3'd5, 1'b0, 8'hFF, 4'b0000);
        idle(4'b0000);
        check("c037_err", 64'(err), 64'(1));
        check("c037_drop_cnt", 64'(drop_cnt), 64'(1));
        check("c037_valid", 64'(y_valid), 64'(4'b0010));
        idle(4'b0000);
        check("c037_err_cleared", 64'(err), 64'(0));
        for (int i = 0; i < 299; i++) begin
            step(1'b1, 3'(4 + $urandom_range(0, 3)), 1'b0, 8'($urandom), 4'($urandom));
        end
        idle(4'b0000);
        check("c037_saturated", 64'(drop_cnt), 64'(255));
        check("c037_err_after_sat", 64'(err), 64'(1));
        idle(4'b1111);

        // asynchronous reset with three channels occupied
        step(1'b1, 3'd0, 1'b0, 8'hC0, 4'b0000);
        step(1'b1, 3'd1, 1'b0, 8'hC1, 4'b0000);
        step(1'b1, 3'd3, 1'b0, 8'hC3, 4'b0000);
        idle(4'b0000);
        check("c038_before", 64'(y_valid), 64'(4'b1011));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("c038_valid", 64'(y_valid), 64'(0));
        check("c038_y", 64'(y), 64'(0));
        check("c038_drop_cnt", 64'(drop_cnt), 64'(0));
        check("c038_err", 64'(err), 64'(0));
        model_clear();
        in_valid = 1'b1;
        bcast    = 1'b1;
        d        = 8'h99;
        y_ready  = 4'b0000;
        @(posedge clk);
        #1;
        check("reset_offer_ignored", 64'(y_valid), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        #2 rst = 1'b0;
        #1;
        evaluate();
        idle(4'b0000);
        check("post_reset_accept", 64'(y_valid), 64'(4'b1111));
        idle(4'b1111);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [SELW-1:0] s;
            s = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) s = 3'd7;
            step($urandom_range(0, 3) != 0, s, $urandom_range(0, 5) == 0,
                 8'($urandom), 4'($urandom));
        end
        idle(4'b1111);
        idle(4'b1111);
        for (int k = 0; k < N; k++) check($sformatf("drained_ch%0d", k), 64'(exp_q[k].size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
